div_seq: RTL

Multi-cycle sequencer for the 32-bit integer divider used by DIVW, MODW, DIVWU and MODWU in the execute stage. Decode issues these ops with both source operands, and this block runs them with a radix-2 restoring iteration. It raises a pipeline pause while the operation is in flight. It then holds quotient and remainder stable until execute drops its request, so the hazard controller can freeze IF/ID/EX around it.

---
 rtl/div_seq_if.sv | 24 ++
 rtl/div_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/div_seq_if.sv
// Divide request/response bundle between the execute stage and the divider sequencer.
interface div_seq_if;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        cancel_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        ready_o;
    logic        pause_o;

    // Execute-stage side: issues the request, consumes the result.
    modport master (
        output start_i, signed_i, dividend_i, divisor_i, cancel_i,
        input  quotient_o, remainder_o, ready_o, pause_o
    );

    // Divider side.
    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i, cancel_i,
        output quotient_o, remainder_o, ready_o, pause_o
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider sequencer for DIVW/MODW/DIVWU/MODWU.
module div_seq (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dvd_q;      // dividend magnitude, shifts out MSB-first while quotient shifts in
    logic [WIDTH-1:0]   dvsr_q;     // divisor magnitude
    logic [WIDTH-1:0]   raw_q;      // unmodified dividend for the divide-by-zero result
    logic [WIDTH-1:0]   rem_q;
    logic               q_neg_q, r_neg_q;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   dvd_mag, dvsr_mag;
    logic [WIDTH:0]     rem_sh, diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nx, quo_nx, quo_fix, rem_fix;

    // Request acceptance and operand magnitudes.
    always_comb begin
        accept   = bus.start_i && !bus.cancel_i;
        dvd_mag  = (bus.signed_i && bus.dividend_i[WIDTH-1]) ? WIDTH'(0) - bus.dividend_i : bus.dividend_i;
        dvsr_mag = (bus.signed_i && bus.divisor_i[WIDTH-1])  ? WIDTH'(0) - bus.divisor_i  : bus.divisor_i;
    end

    // One restoring step plus the sign fix-up applied on the final step.
    always_comb begin
        rem_sh    = {rem_q, dvd_q[WIDTH-1]};
        diff      = rem_sh - {1'b0, dvsr_q};
        q_bit     = !diff[WIDTH];
        rem_nx    = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx    = {dvd_q[WIDTH-2:0], q_bit};
        quo_fix   = q_neg_q ? WIDTH'(0) - quo_nx : quo_nx;
        rem_fix   = r_neg_q ? WIDTH'(0) - rem_nx : rem_nx;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and combinational pause.
    always_comb begin
        state_d     = state_q;
        bus.pause_o = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = (bus.divisor_i == WIDTH'(0)) ? ZERO : BUSY;
            ZERO: state_d = bus.cancel_i ? IDLE : DONE;
            BUSY: begin
                if (bus.cancel_i)   state_d = IDLE;
                else if (last_iter) state_d = DONE;
            end
            DONE: if (bus.cancel_i || !bus.start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!rst && accept && state_q != DONE) bus.pause_o = 1'b1;
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvsr_q  <= '0;
            raw_q   <= '0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (state_q == IDLE && accept) begin
            cnt_q   <= '0;
            dvd_q   <= dvd_mag;
            dvsr_q  <= dvsr_mag;
            raw_q   <= bus.dividend_i;
            rem_q   <= '0;
            q_neg_q <= bus.signed_i && (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
            r_neg_q <= bus.signed_i && bus.dividend_i[WIDTH-1];
        end else if (state_q == BUSY && !bus.cancel_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            dvd_q <= quo_nx;
            rem_q <= rem_nx;
        end
    end

    // Registered result: loaded on DONE entry, cleared by reset or cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ready_o     <= 1'b0;
            bus.quotient_o  <= '0;
            bus.remainder_o <= '0;
        end else begin
            bus.ready_o <= (state_d == DONE);
            if (state_q != IDLE && bus.cancel_i) begin
                bus.quotient_o  <= '0;
                bus.remainder_o <= '0;
            end else if (state_q == ZERO) begin
                bus.quotient_o  <= '1;
                bus.remainder_o <= raw_q;
            end else if (state_q == BUSY && last_iter) begin
                bus.quotient_o  <= quo_fix;
                bus.remainder_o <= rem_fix;
            end
        end
    end
endmodule
